// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath (shared ALU, unified memory).
// Optional jal/jr support is compiled in when the JAL_JR_EN macro is defined.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_EXECUTE  = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_ADDIEXEC = 4'd9,
    ST_ADDIWB   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_JAL      = 4'd12,
    ST_JR       = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef JAL_JR_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
`endif

  state_t r_state;
  state_t w_next;
  logic   w_pcwrite;
  logic   w_branch;
  logic   w_memwrite;
  logic   w_irwrite;
  logic   w_regwrite;
  logic   w_illegal;

  function automatic logic f_rtype_legal(input logic [5:0] fn);
    case (fn)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: f_rtype_legal = 1'b1;
      default:                                                f_rtype_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] f_alu_dec(input logic [5:0] fn);
    case (fn)
      6'b100010: f_alu_dec = 3'b110;
      6'b100100: f_alu_dec = 3'b000;
      6'b100101: f_alu_dec = 3'b001;
      6'b101010: f_alu_dec = 3'b111;
      default:   f_alu_dec = 3'b010;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = ST_FETCH;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    regdst     = 2'b00;
    memtoreg   = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    case (r_state)
      ST_FETCH: begin
        w_irwrite = 1'b1;
        alusrcb   = 2'b01;
        w_pcwrite = 1'b1;
        w_next    = ST_DECODE;
      end
      ST_DECODE: begin
        // ALUOut captures the branch target while the opcode is resolved
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_RTYPE: begin
`ifdef JAL_JR_EN
            if (funct == FN_JR)            w_next = ST_JR;
            else if (f_rtype_legal(funct)) w_next = ST_EXECUTE;
            else                           w_illegal = 1'b1;
`else
            if (f_rtype_legal(funct)) w_next = ST_EXECUTE;
            else                      w_illegal = 1'b1;
`endif
          end
          OP_BEQ:  w_next = ST_BRANCH;
          OP_ADDI: w_next = ST_ADDIEXEC;
          OP_J:    w_next = ST_JUMP;
`ifdef JAL_JR_EN
          OP_JAL:  w_next = ST_JAL;
`endif
          default: w_illegal = 1'b1;
        endcase
      end
      ST_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        iord   = 1'b1;
        w_next = ST_MEMWB;
      end
      ST_MEMWB: begin
        memtoreg   = 2'b01;
        w_regwrite = 1'b1;
      end
      ST_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      ST_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = f_alu_dec(funct);
        w_next     = ST_ALUWB;
      end
      ST_ALUWB: begin
        regdst     = 2'b01;
        w_regwrite = 1'b1;
      end
      ST_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        w_branch   = 1'b1;
      end
      ST_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      ST_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
`ifdef JAL_JR_EN
      // Link register takes the already-incremented PC on the same edge the PC jumps
      ST_JAL: begin
        regdst     = 2'b10;
        memtoreg   = 2'b10;
        w_regwrite = 1'b1;
        pcsrc      = 2'b10;
        w_pcwrite  = 1'b1;
      end
      ST_JR: begin
        pcsrc     = 2'b11;
        w_pcwrite = 1'b1;
      end
`endif
      default: w_next = ST_FETCH;
    endcase
  end

  // Write strobes are squashed combinationally so a mid-instruction reset writes nothing
  assign pcen     = reset & (w_pcwrite | (w_branch & zero));
  assign memwrite = reset & w_memwrite;
  assign irwrite  = reset & w_irwrite;
  assign regwrite = reset & w_regwrite;
  assign illegal  = reset & w_illegal;
  assign state    = reset ? r_state : 4'd0;

endmodule
